// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared geometry and controller state for the OpenRAM port-0 initiator.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W     = 8;
    localparam int SRAM_DATA_W     = 32;
    localparam int SRAM_NUM_WMASKS = 4;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: small synchronous FIFO holding read responses until the consumer takes them.
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign dout  = mem_q[rd_ptr_q];
    assign empty = count_q == '0;
    assign count = count_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sram_port0_master.sv
// sram_port0_master: valid/ready initiator for port 0 of the OpenRAM SRAM macro,
// with registered macro drive, in-order read responses and optional zero-fill after reset.
module sram_port0_master
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = SRAM_ADDR_W,
    parameter int DATA_WIDTH     = SRAM_DATA_W,
    parameter int NUM_WMASKS     = SRAM_NUM_WMASKS,
    parameter int RSP_DEPTH      = 4,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wstrb,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  csb_q, csb_d, web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  rd0_q, rd0_d, rd1_q, rd1_d;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count, cnt;

    // Credits = reads still in the macro pipeline plus responses already queued.
    assign cnt         = fifo_count + CW'(rd0_q) + CW'(rd1_q);
    assign init_done   = state_q == ST_RUN;
    assign req_ready   = init_done && (cnt < CW'(RSP_DEPTH));
    assign rsp_valid   = !fifo_empty;
    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        csb_d      = 1'b1;
        web_d      = 1'b1;
        wmask_d    = wmask_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rd0_d      = 1'b0;
        rd1_d      = rd0_q;
        if (state_q == ST_INIT) begin
            csb_d      = 1'b0;
            web_d      = 1'b0;
            wmask_d    = '1;
            addr_d     = clr_addr_q;
            din_d      = '0;
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            state_d    = &clr_addr_q ? ST_RUN : ST_INIT;
        end else if (req_valid && req_ready) begin
            csb_d   = 1'b0;
            web_d   = !req_we;
            wmask_d = req_wstrb;
            addr_d  = req_addr;
            din_d   = req_wdata;
            rd0_d   = !req_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
            clr_addr_q <= '0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            rd0_q      <= 1'b0;
            rd1_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            wmask_q    <= wmask_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
        end
    end

    // rd1_q marks the cycle in which the macro's dout0 holds the read issued two edges ago.
    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd1_q),
        .pop   (rsp_valid && rsp_ready),
        .din   (sram_dout0),
        .dout  (rsp_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_sram_port0_master.sv
// tb_sram_port0_master: directed and random traffic against a behavioural macro model,
// checked by a word-array reference and an in-order expected-response queue.
module tb_sram_port0_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NW = 4;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [NW-1:0] req_wstrb = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_csb0, sram_web0;
    logic [NW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_rsp = 0;
    logic acc = 1'b0;
    logic got = 1'b0;
    logic hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic [DW-1:0] last_rsp = '0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int rsp_cyc_q [$];

    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    sram_port0_master #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_wstrb   (req_wstrb),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // Macro model: captures on clk0, dout holds until the next read.
    always @(posedge clk) begin
        if (!sram_csb0 && !sram_web0) begin
            for (int b = 0; b < NW; b++) begin
                if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end
        end else if (!sram_csb0) begin
            sram_dout0 <= mem[sram_addr0];
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes mid-cycle, update the reference, advance to the next negedge.
    task automatic tick();
        logic [DW-1:0] e;
        #2;
        acc = rst_n && req_valid && req_ready;
        got = rst_n && rsp_valid && rsp_ready;
        if (hold_v && rst_n && rsp_valid) chk("rsp_hold", rsp_rdata, hold_d);
        hold_v = rst_n && rsp_valid && !rsp_ready;
        hold_d = rsp_rdata;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end
        if (got) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL rsp_unexpected obs=0x%08h exp=none", rsp_rdata);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_data", rsp_rdata, e);
            end
            last_rsp = rsp_rdata;
            n_rsp++;
            rsp_cyc_q.push_back(cyc);
        end
        if (acc && req_we) begin
            for (int b = 0; b < NW; b++) begin
                if (req_wstrb[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end
        end else if (acc) begin
            exp_q.push_back(ref_mem[req_addr]);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NW-1:0] s);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_wstrb = s;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        req_valid = 1'b0;
        chk("req_accept_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, idx, n0;
        @(negedge clk);
        // Reset with a stale word planted in the macro that the clear must overwrite.
        bd_we = 1'b1;
        bd_addr = 8'h30;
        bd_data = 32'h12345678;
        repeat (3) tick();
        bd_we = 1'b0;
        chk("rst_csb0", 32'(sram_csb0), 32'd1);
        chk("rst_web0", 32'(sram_web0), 32'd1);
        chk("rst_wmask0", 32'(sram_wmask0), 32'd0);
        chk("rst_addr0", 32'(sram_addr0), 32'd0);
        chk("rst_din0", sram_din0, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("prefill", mem[8'h30], 32'h12345678);

        rst_n = 1'b1;
        repeat (100) tick();
        chk("init_req_ready", 32'(req_ready), 32'd0);
        wait_init(n);
        chk("init_done_cycles", 32'(n + 100), 32'd256);
        chk("init_done_high", 32'(init_done), 32'd1);

        rsp_ready = 1'b1;
        do_req(1'b0, 8'h30, '0, '0);
        drain();
        chk("clear_0x30", last_rsp, 32'h00000000);

        do_req(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 8'h10, '0, '0);
        chk("lat_edge0", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat_edge1", 32'(rsp_valid), 32'd0);
        tick();
        chk("lat_edge2", 32'(rsp_valid), 32'd1);
        chk("lat_data", rsp_rdata, 32'hDEADBEEF);
        drain();

        do_req(1'b1, 8'h11, 32'h11223344, 4'hF);
        do_req(1'b1, 8'h11, 32'h0000AB00, 4'b0010);
        do_req(1'b0, 8'h11, '0, '0);
        drain();
        chk("wstrb_merge", last_rsp, 32'h1122AB44);
        do_req(1'b1, 8'h11, 32'hFFFFFFFF, 4'b0000);
        do_req(1'b0, 8'h11, '0, '0);
        drain();
        chk("wstrb_zero", last_rsp, 32'h1122AB44);

        for (int i = 0; i < 6; i++) do_req(1'b1, AW'(8'h20 + i), $urandom, 4'hF);
        rsp_ready = 1'b0;
        idx = 0;
        req_valid = 1'b1;
        req_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_addr = AW'(8'h20 + idx);
            tick();
            if (acc) idx++;
        end
        chk("credit_accepted", 32'(idx), 32'd4);
        chk("credit_req_ready", 32'(req_ready), 32'd0);
        n0 = n_rsp;
        rsp_ready = 1'b1;
        n = 0;
        while (idx < 6 && n < 50) begin
            req_addr = AW'(8'h20 + idx);
            tick();
            if (acc) idx++;
            n++;
        end
        req_valid = 1'b0;
        drain();
        chk("credit_rsp_count", 32'(n_rsp - n0), 32'd6);

        rsp_cyc_q.delete();
        idx = 0;
        n = 0;
        req_valid = 1'b1;
        while (idx < 8 && n < 50) begin
            req_addr = AW'(idx);
            tick();
            if (acc) idx++;
            n++;
        end
        req_valid = 1'b0;
        drain();
        chk("b2b_accept_cycles", 32'(n), 32'd8);
        chk("b2b_rsp_count", 32'(rsp_cyc_q.size()), 32'd8);
        if (rsp_cyc_q.size() == 8) chk("b2b_rsp_span", 32'(rsp_cyc_q[7] - rsp_cyc_q[0]), 32'd7);

        for (int i = 0; i < 400; i++) begin
            rsp_ready = $urandom_range(0, 3) != 0;
            req_valid = $urandom_range(0, 1) == 1;
            req_we = $urandom_range(0, 1) == 1;
            req_addr = AW'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_wstrb = NW'($urandom_range(0, 15));
            tick();
        end
        req_valid = 1'b0;
        drain();

        rsp_ready = 1'b0;
        do_req(1'b0, 8'h40, '0, '0);
        repeat (2) tick();
        do_req(1'b0, 8'h41, '0, '0);
        do_req(1'b0, 8'h42, '0, '0);
        chk("midrst_pending", 32'(exp_q.size()), 32'd3);
        rst_n = 1'b0;
        tick();
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_csb0", 32'(sram_csb0), 32'd1);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        n0 = n_rsp;
        wait_init(n);
        chk("midrst_init_cycles", 32'(n), 32'd256);
        repeat (5) tick();
        chk("midrst_no_rsp", 32'(n_rsp - n0), 32'd0);
        do_req(1'b1, 8'h05, 32'hCAFEF00D, 4'hF);
        do_req(1'b0, 8'h05, '0, '0);
        drain();
        chk("post_rst_rw", last_rsp, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
